// File: rtl/imm_pkg.sv
// imm_pkg: shared mode codes and state encoding for the immediate extension controller
package imm_pkg;
  localparam logic [1:0] MODE_ZEXT = 2'b00;
  localparam logic [1:0] MODE_SEXT = 2'b01;
  localparam logic [1:0] MODE_PAIR = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    FULL    = 2'd2
  } state_e;
endpackage

// File: rtl/imm_ext_unit.sv
// imm_ext_unit: combinational 8-to-16 zero/sign extender
module imm_ext_unit (
  input  logic [7:0]  in,
  input  logic        sext,
  output logic [15:0] out
);
  assign out = {{8{sext & in[7]}}, in};
endmodule

// File: rtl/imm_extend_ctrl.sv
// imm_extend_ctrl: byte-stream sequencer producing zero/sign-extended or paired 16-bit immediates.
// Optional IMM_ERR_EN adds err_o and drops reserved-mode bytes instead of zero-extending them.
module imm_extend_ctrl
  import imm_pkg::*;
#(
  parameter int HI_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_data_i,
  input  logic [1:0]  in_mode_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_data_o,
  output logic        timeout_o,
`ifdef IMM_ERR_EN
  output logic        err_o,
`endif
  output logic        busy_o
);
  localparam int CW = (HI_TIMEOUT < 1) ? 1 : $clog2(HI_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [7:0] lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d, ext;
  logic to_q, to_d, acc;
`ifdef IMM_ERR_EN
  logic err_q, err_d;
  assign err_o = err_q;
`endif
  assign acc = in_valid_i && in_ready_o;
  assign in_ready_o = state_q != FULL;
  assign out_valid_o = state_q == FULL;
  assign busy_o = state_q != IDLE;
  assign out_data_o = data_q;
  assign timeout_o = to_q;
  imm_ext_unit u_ext (.in(in_data_i), .sext(in_mode_i == MODE_SEXT), .out(ext));
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    cnt_d = cnt_q;
    data_d = data_q;
    to_d = 1'b0;
`ifdef IMM_ERR_EN
    err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (acc) begin
        if (in_mode_i == MODE_PAIR) begin
          lo_d = in_data_i;
          cnt_d = '0;
          state_d = WAIT_HI;
        end
`ifdef IMM_ERR_EN
        else if (in_mode_i == MODE_RSVD) err_d = 1'b1;
`endif
        else begin
          data_d = ext;
          state_d = FULL;
        end
      end
      WAIT_HI: if (acc) begin
        data_d = {in_data_i, lo_q};
        state_d = FULL;
      end else if (HI_TIMEOUT != 0 && cnt_q == CW'(HI_TIMEOUT)) begin
        to_d = 1'b1;
        lo_d = '0;
        state_d = IDLE;
      end else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      FULL: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      lo_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      to_q <= 1'b0;
`ifdef IMM_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      to_q <= to_d;
`ifdef IMM_ERR_EN
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_imm_extend_ctrl.sv
// tb_imm_extend_ctrl: directed table, corner sequences and random traffic against a queue-based model
module tb_imm_extend_ctrl;
  localparam int T = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, timeout, busy;
  logic [7:0] in_data = '0;
  logic [1:0] in_mode = '0;
  logic [15:0] out_data;
`ifdef IMM_ERR_EN
  logic err;
`endif
  int n_cmp = 0, n_bad = 0;

  imm_extend_ctrl #(.HI_TIMEOUT(T)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_mode_i(in_mode), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .timeout_o(timeout),
`ifdef IMM_ERR_EN
    .err_o(err),
`endif
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  bit has_lo, exp_to, exp_err;
  int lo_v, waited;
  int pend[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    has_lo = 0; exp_to = 0; exp_err = 0; waited = 0; lo_v = 0;
    pend.delete();
  endtask

  function automatic int extend(input int b, input bit s);
    return (s && b >= 128) ? b + 'hFF00 : b;
  endfunction

  task automatic model_step();
    exp_to = 0; exp_err = 0;
    if (pend.size() != 0) begin
      if (out_ready) void'(pend.pop_front());
    end else if (in_valid) begin
      if (has_lo) begin
        pend.push_back(int'(in_data) * 256 + lo_v);
        has_lo = 0;
      end else if (in_mode == 2'b10) begin
        has_lo = 1; lo_v = int'(in_data); waited = 0;
      end
`ifdef IMM_ERR_EN
      else if (in_mode == 2'b11) exp_err = 1;
`endif
      else pend.push_back(extend(int'(in_data), in_mode == 2'b01));
    end else if (has_lo) begin
      if (waited == T) begin
        has_lo = 0; exp_to = 1;
      end else waited++;
    end
  endtask

  task automatic check_model();
    chk("out_valid", int'(out_valid), int'(pend.size() != 0));
    chk("in_ready", int'(in_ready), int'(pend.size() == 0));
    chk("busy", int'(busy), int'(has_lo || pend.size() != 0));
    chk("timeout", int'(timeout), int'(exp_to));
`ifdef IMM_ERR_EN
    chk("err", int'(err), int'(exp_err));
`endif
    if (pend.size() != 0) chk("out_data", int'(out_data), pend[0]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1 check_model();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d, input logic r);
    in_valid = v; in_mode = m; in_data = d; out_ready = r;
  endtask

  typedef struct {
    logic v; logic [1:0] m; logic [7:0] d; logic r;
    logic ev; logic [15:0] ed; logic eb; logic eto;
  } vec_t;
  vec_t vt[17];

  initial begin
    int to_cnt, to_at, ov_seen;
    vt[0]  = '{1, 2'b00, 8'hF2, 1, 1, 16'h00F2, 1, 0};
    vt[1]  = '{1, 2'b01, 8'hF2, 1, 0, 16'h0000, 0, 0};
    vt[2]  = '{1, 2'b01, 8'hF2, 1, 1, 16'hFFF2, 1, 0};
    vt[3]  = '{0, 2'b00, 8'h00, 1, 0, 16'h0000, 0, 0};
    vt[4]  = '{1, 2'b01, 8'h02, 0, 1, 16'h0002, 1, 0};
    vt[5]  = '{1, 2'b00, 8'h77, 0, 1, 16'h0002, 1, 0};
    vt[6]  = '{1, 2'b10, 8'h77, 0, 1, 16'h0002, 1, 0};
    vt[7]  = '{0, 2'b00, 8'h00, 0, 1, 16'h0002, 1, 0};
    vt[8]  = '{1, 2'b01, 8'hC3, 0, 1, 16'h0002, 1, 0};
    vt[9]  = '{0, 2'b00, 8'h00, 0, 1, 16'h0002, 1, 0};
    vt[10] = '{0, 2'b00, 8'h00, 1, 0, 16'h0000, 0, 0};
    vt[11] = '{1, 2'b10, 8'h34, 0, 0, 16'h0000, 1, 0};
    vt[12] = '{0, 2'b00, 8'h00, 0, 0, 16'h0000, 1, 0};
    vt[13] = '{0, 2'b00, 8'h00, 0, 0, 16'h0000, 1, 0};
    vt[14] = '{0, 2'b00, 8'h00, 0, 0, 16'h0000, 1, 0};
    vt[15] = '{1, 2'b01, 8'h12, 0, 1, 16'h1234, 1, 0};
    vt[16] = '{0, 2'b00, 8'h00, 1, 0, 16'h0000, 0, 0};
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout), 0);
`ifdef IMM_ERR_EN
    chk("rst_err", int'(err), 0);
`endif
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].v, vt[i].m, vt[i].d, vt[i].r);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vt[i].ev));
      chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(!vt[i].ev));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].eb));
      chk($sformatf("vec%0d_timeout", i), int'(timeout), int'(vt[i].eto));
      if (vt[i].ev) chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vt[i].ed));
      @(negedge clk);
    end
    model_reset();
    to_cnt = 0; to_at = -1; ov_seen = 0;
    drive(1, 2'b10, 8'hAA, 1);
    tick();
    drive(0, 2'b00, 8'h00, 1);
    for (int i = 1; i <= T + 3; i++) begin
      tick();
      if (timeout) begin to_cnt++; to_at = i; end
      if (out_valid) ov_seen++;
    end
    chk("to_pulses", to_cnt, 1);
    chk("to_edge", to_at, T + 1);
    chk("to_no_output", ov_seen, 0);
    drive(1, 2'b00, 8'h01, 1);
    tick();
    chk("after_to_data", int'(out_data), 16'h0001);
    drive(0, 2'b00, 8'h00, 1);
    tick();
    drive(1, 2'b10, 8'h99, 0);
    tick();
    drive(0, 2'b00, 8'h00, 0);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    chk("mid_rst_timeout", int'(timeout), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(1, 2'b00, 8'h55, 0);
    tick();
    chk("post_rst_data", int'(out_data), 16'h0055);
    drive(0, 2'b00, 8'h00, 1);
    tick();
    drive(1, 2'b11, 8'h80, 1);
    tick();
`ifdef IMM_ERR_EN
    chk("rsvd_err", int'(err), 1);
    chk("rsvd_no_out", int'(out_valid), 0);
`else
    chk("rsvd_zext", int'(out_data), 16'h0080);
`endif
    drive(0, 2'b00, 8'h00, 1);
    tick();
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 250) % 4;
      drive($urandom_range(0, 3) < dens + 1 && dens != 3 || $urandom_range(0, 9) == 0,
            2'($urandom), 8'($urandom), 1'($urandom));
      tick();
    end
    drive(0, 2'b00, 8'h00, 1);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
